// File: rtl/control_unit.sv
// control_unit: sequencing FSM for a small accumulator datapath.
// It accepts one operation (ADD, SUB, AND, MUL) per start request, walks the
// datapath through load / clear / execute / store, and raises done for one
// cycle at the end. MUL runs as a four-step shift-and-add loop that is steered
// by the shifter LSB flag.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-low reset
//   start    in   1   begin one operation (sampled in IDLE only)
//   op       in   2   00 ADD, 01 SUB, 10 AND, 11 MUL (sampled with start)
//   flag     in   1   shifter LSB flag from the datapath
//   control  out  16  datapath control word (combinational decode)
//   step     out  2   MUL iteration index (0 outside the MUL loop)
//   busy     out  1   high in every state except IDLE
//   done     out  1   one-cycle pulse in DONE
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        flag,
    output logic [15:0] control,
    output logic [1:0]  step,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned STEP_W = 2;

    // Control word bit positions
    localparam int unsigned B_LOAD_A     = 0;
    localparam int unsigned B_LOAD_B     = 1;
    localparam int unsigned B_LOAD_O     = 2;
    localparam int unsigned B_SEL_A      = 3;
    localparam int unsigned B_SEL_B      = 4;
    localparam int unsigned B_SHIFT_LOAD = 5;
    localparam int unsigned B_SHIFT_L    = 6;
    localparam int unsigned B_SHIFT_R    = 7;
    localparam int unsigned B_MUX2_SHIFT = 8;
    localparam int unsigned B_ALU_ADD    = 9;
    localparam int unsigned B_ALU_SUB    = 10;
    localparam int unsigned B_ALU_AND    = 11;
    localparam int unsigned B_ALU_OR     = 12;
    localparam int unsigned B_ACC_CLR    = 13;
    localparam int unsigned B_ACC_LD     = 14;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_AND = 2'b10;
    localparam logic [OP_W-1:0] OP_MUL = 2'b11;

    localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_CLEAR    = 4'd2,
        ST_EXEC1    = 4'd3,
        ST_EXEC2    = 4'd4,
        ST_MUL_INIT = 4'd5,
        ST_MUL_ITER = 4'd6,
        ST_STORE    = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [OP_W-1:0]   op_q;
    logic [OP_W-1:0]   op_next;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_next;
    logic              busy_next;
    logic              done_next;

    // State, latched op, MUL step counter and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_ADD;
            step_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            op_q   <= op_next;
            step_q <= step_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    // Next-state logic; the step counter holds 0 everywhere except the MUL loop
    always_comb begin
        state_next = state;
        op_next    = op_q;
        step_next  = '0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    op_next    = op;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD:     state_next = ST_CLEAR;
            ST_CLEAR:    state_next = (op_q == OP_MUL) ? ST_MUL_INIT : ST_EXEC1;
            ST_EXEC1:    state_next = ST_EXEC2;
            ST_EXEC2:    state_next = ST_STORE;
            ST_MUL_INIT: state_next = ST_MUL_ITER;
            ST_MUL_ITER: begin
                step_next = step_q + STEP_W'(1);
                if (step_q == STEP_LAST) begin
                    state_next = ST_STORE;
                end
            end
            ST_STORE:    state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase

        // Status flags are registered from the upcoming state
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    // Control word decode from state and latched op (and flag in the MUL loop)
    always_comb begin
        control = '0;

        unique case (state)
            ST_LOAD: begin
                control[B_LOAD_A] = 1'b1;
                control[B_LOAD_B] = 1'b1;
            end
            ST_CLEAR: begin
                control[B_ACC_CLR] = 1'b1;
            end
            ST_EXEC1: begin
                control[B_SEL_A]   = 1'b1;
                control[B_ALU_ADD] = 1'b1;
                control[B_ACC_LD]  = 1'b1;
            end
            ST_EXEC2: begin
                control[B_SEL_B]  = 1'b1;
                control[B_ACC_LD] = 1'b1;
                // op 11 never reaches EXEC2; it shares the ADD word
                case (op_q)
                    OP_SUB:  control[B_ALU_SUB] = 1'b1;
                    OP_AND:  control[B_ALU_AND] = 1'b1;
                    default: control[B_ALU_ADD] = 1'b1;
                endcase
            end
            ST_MUL_INIT: begin
                control[B_SEL_A]      = 1'b1;
                control[B_SHIFT_LOAD] = 1'b1;
            end
            ST_MUL_ITER: begin
                control[B_SHIFT_R] = 1'b1;
                // Add the shifted multiplicand only when the current LSB is set
                if (flag) begin
                    control[B_SEL_B]      = 1'b1;
                    control[B_MUX2_SHIFT] = 1'b1;
                    control[B_ALU_ADD]    = 1'b1;
                    control[B_ACC_LD]     = 1'b1;
                end
            end
            ST_STORE: begin
                control[B_LOAD_O] = 1'b1;
            end
            default: begin
                control = '0;
            end
        endcase
    end

    assign step = step_q;

    // Bit positions kept for documentation of the full control map
    logic unused_bits;
    assign unused_bits = ^{CTRL_W'(B_SHIFT_L), CTRL_W'(B_ALU_OR), OP_ADD};

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have the port: clk  input  1  system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port: reset  input  1  reset; asynchronous, active-low.
REQ-003 The block SHALL have the port: start  input  1  request to begin one operation; sampled only in IDLE.
REQ-004 The block SHALL have the port: op  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 MUL.
REQ-005 The block SHALL have the port: flag  input  1  shifter LSB flag from the datapath.
REQ-006 The block SHALL have the port: control  output  16  datapath control word.
REQ-007 The block SHALL have the port: step  output  2  MUL iteration index.
REQ-008 The block SHALL have the port: busy  output  1  high in every state except IDLE.
REQ-009 The block SHALL have the port: done  output  1  high for exactly one cycle, in state DONE only.

Function
REQ-010 The control bit map SHALL be: 0 LOAD_A, 1 LOAD_B, 2 LOAD_O, 3 SEL_A, 4 SEL_B, 5 SHIFT_LOAD, 6 SHIFT_L, 7 SHIFT_R, 8 MUX2_SHIFT, 9 ALU_ADD, 10 ALU_SUB, 11 ALU_AND, 12 ALU_OR, 13 ACC_CLR, 14 ACC_LD, 15 reserved (always 0).
REQ-011 The FSM SHALL have the states IDLE, LOAD, CLEAR, EXEC1, EXEC2, MUL_INIT, MUL_ITER, STORE and DONE.
REQ-012 In IDLE with start=1, the FSM SHALL latch op into an internal register and go to LOAD; with start=0 it SHALL stay in IDLE.
REQ-013 The FSM SHALL make these unconditional transitions: LOAD->CLEAR, EXEC1->EXEC2, EXEC2->STORE, MUL_INIT->MUL_ITER, STORE->DONE, DONE->IDLE.
REQ-014 From CLEAR, the FSM SHALL go to MUL_INIT if the latched op is 11, and to EXEC1 otherwise.
REQ-015 MUL_ITER SHALL last exactly 4 cycles, counted by a 2-bit counter that is cleared in MUL_INIT, increments each MUL_ITER cycle and drives step; when step=3, the FSM SHALL go to STORE.
REQ-016 control SHALL be decoded combinationally from state and latched op; in MUL_ITER only, it SHALL also depend on flag.
REQ-017 In IDLE and DONE, control SHALL be 0x0000.
REQ-018 In LOAD, control SHALL be 0x0003; in CLEAR, 0x2000; in STORE, 0x0004.
REQ-019 In EXEC1, control SHALL be 0x4208 (SEL_A, ADD, ACC_LD) for all ops.
REQ-020 In EXEC2, control SHALL be 0x4210 for ADD, 0x4410 for SUB and 0x4810 for AND.
REQ-021 In MUL_INIT, control SHALL be 0x0028 (SEL_A, SHIFT_LOAD).
REQ-022 In MUL_ITER, control SHALL be 0x0080 when flag=0, and 0x4390 (SHIFT_R, SEL_B, MUX2_SHIFT, ADD, ACC_LD) when flag=1.
REQ-023 Outside MUL_INIT and MUL_ITER, step SHALL be 0.
REQ-024 For ADD, SUB and AND, done SHALL assert in the 6th cycle after the edge that accepts start; for MUL, in the 9th cycle.
REQ-025 start SHALL be ignored while busy=1; the op input SHALL be ignored while busy=1.
REQ-026 A start held high through DONE SHALL be accepted on the first IDLE cycle, so back-to-back operations have one IDLE cycle between them.
REQ-027 control SHALL never assert LOAD_O (bit 2) and ACC_LD (bit 14) in the same cycle.
REQ-028 Exactly one of SEL_A and SEL_B SHALL be asserted whenever ALU_* or SHIFT_LOAD is asserted.

Reset
REQ-029 While reset=0, the block SHALL force the state to IDLE, the step counter to 0 and the latched op to 00, asynchronously.
REQ-030 While reset=0, control SHALL be 0x0000 and busy and done SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort that operation immediately, with no STORE or DONE cycle.
REQ-032 After reset deasserts, the first start SHALL be sampled on the next rising clk edge.

Verification
REQ-033 The bench SHALL cover: reset low -> control=0x0000, busy=0, done=0; reset high, start=1, op=00 -> control sequence 0x0003, 0x2000, 0x4208, 0x4210, 0x0004, 0x0000 with done=1 in the last cycle.
REQ-034 The bench SHALL cover: op=01 and op=10 -> EXEC2 is 0x4410 and 0x4810 respectively; the rest of each sequence matches ADD.
REQ-035 The bench SHALL cover: op=11 with flag pattern 1,0,1,1 over MUL_ITER -> 0x4390, 0x0080, 0x4390, 0x4390 with step 0,1,2,3, then 0x0004, then done=1 in the 9th cycle.
REQ-036 The bench SHALL cover: start pulsed and op changed during EXEC1 -> no restart and the latched op is unchanged; start held high continuously -> DONE, one IDLE cycle, then LOAD.
REQ-037 The bench SHALL cover: reset pulsed low during MUL_ITER with step=2 -> control=0x0000 immediately, no LOAD_O; the next start runs a full sequence.
REQ-038 The bench SHALL check the REQ-027 and REQ-028 properties on every cycle of every scenario.
